// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between the
// instruction cache and the data cache.
module cache_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [LINE_W-1:0] i_wdata,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata,
    output logic [1:0]        grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } state_e;

    state_e state_q, state_d;
    // 1: data cache owned the last completed transaction
    logic   last_d_q, last_d_d;

    logic req_i, req_d;

    assign req_i = i_read | i_write;
    assign req_d = d_read | d_write;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_d_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_d_d     = last_d_q;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_i && req_d) begin
                    state_d = last_d_q ? GNT_I : GNT_D;
                end else if (req_i) begin
                    state_d = GNT_I;
                end else if (req_d) begin
                    state_d = GNT_D;
                end
            end
            GNT_I: begin
                // write wins when a client raises both strobes
                pmem_read    = i_read & ~i_write;
                pmem_write   = i_write;
                pmem_address = i_address;
                pmem_wdata   = i_wdata;
                i_resp       = pmem_resp;
                if (pmem_resp) begin
                    state_d  = IDLE;
                    last_d_d = 1'b0;
                end else if (!req_i) begin
                    state_d = IDLE;
                end
            end
            GNT_D: begin
                pmem_read    = d_read & ~d_write;
                pmem_write   = d_write;
                pmem_address = d_address;
                pmem_wdata   = d_wdata;
                d_resp       = pmem_resp;
                if (pmem_resp) begin
                    state_d  = IDLE;
                    last_d_d = 1'b1;
                end else if (!req_d) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant   = state_q;
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: grant order, muxing, responses
// and reset/abort behaviour.
module tb_cache_arbiter;

    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_read, i_write;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_wdata;
    logic              i_resp;
    logic [LINE_W-1:0] i_rdata;
    logic              d_read, d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic              d_resp;
    logic [LINE_W-1:0] d_rdata;
    logic              pmem_read, pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic              pmem_resp;
    logic [LINE_W-1:0] pmem_rdata;
    logic [1:0]        grant;

    int total  = 0;
    int passed = 0;

    cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_write(i_write), .i_address(i_address),
        .i_wdata(i_wdata), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_address(d_address),
        .d_wdata(d_wdata), .d_resp(d_resp), .d_rdata(d_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
        .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [1:0]        exp_order [4];
    logic [LINE_W-1:0] good_line;

    initial begin
        exp_order[0] = 2'b01;
        exp_order[1] = 2'b10;
        exp_order[2] = 2'b01;
        exp_order[3] = 2'b10;
        good_line    = {8{16'h600D}};

        rst_n = 1'b0;
        i_read = 0; i_write = 0; i_address = '0; i_wdata = '0;
        d_read = 0; d_write = 0; d_address = '0; d_wdata = '0;
        pmem_resp = 0; pmem_rdata = 128'hCAFE_0000_1111_2222_3333_4444_5555_6666;
        tick(); tick();

        // reset state
        chk("rst_grant", grant, 2'b00);
        chk("rst_pread", pmem_read, 1'b0);
        chk("rst_pwrite", pmem_write, 1'b0);
        chk("rst_paddr", pmem_address, 16'h0);
        chk("rst_iresp", i_resp, 1'b0);
        chk("rst_irdata", i_rdata, pmem_rdata);
        chk("rst_drdata", d_rdata, 128'hCAFE_0000_1111_2222_3333_4444_5555_6666);

        // single I read of 0x0010
        rst_n = 1'b1;
        i_read = 1; i_address = 16'h0010;
        settle();
        chk("s_pre_grant", grant, 2'b00);
        chk("s_pre_pread", pmem_read, 1'b0);
        tick();
        chk("s_grant", grant, 2'b01);
        chk("s_pread", pmem_read, 1'b1);
        chk("s_paddr", pmem_address, 16'h0010);
        pmem_resp = 1; settle();
        chk("s_iresp", i_resp, 1'b1);
        chk("s_dresp", d_resp, 1'b0);
        tick();
        i_read = 0; pmem_resp = 0; settle();
        chk("s_idle", grant, 2'b00);

        // simultaneous I read and D write just after reset: I first
        rst_n = 0; tick(); rst_n = 1;
        i_read = 1; i_address = 16'h0020;
        d_write = 1; d_address = 16'h1230; d_wdata = good_line;
        tick();
        chk("b_grant_i", grant, 2'b01);
        chk("b_paddr_i", pmem_address, 16'h0020);
        pmem_resp = 1; settle();
        chk("b_iresp", i_resp, 1'b1);
        chk("b_dresp_hold", d_resp, 1'b0);
        tick();
        i_read = 0; pmem_resp = 0; settle();
        chk("b_gap", grant, 2'b00);
        chk("b_gap_pwrite", pmem_write, 1'b0);
        tick();
        chk("b_grant_d", grant, 2'b10);
        chk("b_pwrite", pmem_write, 1'b1);
        chk("b_pread", pmem_read, 1'b0);
        chk("b_paddr_d", pmem_address, 16'h1230);
        chk("b_pwdata", pmem_wdata, good_line);
        pmem_resp = 1; settle();
        chk("b_dresp", d_resp, 1'b1);
        chk("b_iresp0", i_resp, 1'b0);
        tick();
        d_write = 0; pmem_resp = 0; settle();

        // pmem_resp while idle is ignored
        pmem_resp = 1; settle();
        chk("idle_iresp", i_resp, 1'b0);
        chk("idle_dresp", d_resp, 1'b0);
        tick();
        chk("idle_stay", grant, 2'b00);
        pmem_resp = 0;

        // continuous requests from both: I D I D (last owner was D)
        i_read = 1; i_address = 16'h0100;
        d_read = 1; d_address = 16'h0200;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rr_grant%0d", k), grant, exp_order[k]);
            pmem_resp = 1;
            tick();
            pmem_resp = 0; settle();
            chk($sformatf("rr_idle%0d", k), grant, 2'b00);
        end
        i_read = 0; d_read = 0;
        // last owner is now D; run a lone I so I becomes last owner
        i_read = 1; i_address = 16'h0300;
        tick();
        chk("pre_i_grant", grant, 2'b01);
        pmem_resp = 1; tick(); pmem_resp = 0; i_read = 0;

        // dirty miss: D write-back, then I, then D read
        i_read = 1; i_address = 16'h0040;
        d_write = 1; d_read = 1; d_address = 16'h2000; d_wdata = good_line;
        tick();
        chk("dm_wb_grant", grant, 2'b10);
        chk("dm_wb_pwrite", pmem_write, 1'b1);
        chk("dm_wb_pread", pmem_read, 1'b0);
        pmem_resp = 1; settle();
        chk("dm_i_pending", i_resp, 1'b0);
        tick();
        pmem_resp = 0; d_write = 0;
        tick();
        chk("dm_i_grant", grant, 2'b01);
        chk("dm_i_addr", pmem_address, 16'h0040);
        pmem_resp = 1; tick(); pmem_resp = 0; i_read = 0;
        tick();
        chk("dm_rd_grant", grant, 2'b10);
        chk("dm_rd_pread", pmem_read, 1'b1);
        pmem_resp = 1; tick(); pmem_resp = 0; d_read = 0;

        // reset during GNT_D before pmem_resp
        d_read = 1; d_address = 16'h3000;
        tick();
        chk("ra_grant_d", grant, 2'b10);
        rst_n = 0;
        tick();
        chk("ra_grant", grant, 2'b00);
        chk("ra_pread", pmem_read, 1'b0);
        chk("ra_pwrite", pmem_write, 1'b0);
        pmem_resp = 1; settle();
        chk("ra_dresp", d_resp, 1'b0);
        pmem_resp = 0; d_read = 0; rst_n = 1;
        tick();

        // client drops while granted; pending D granted one cycle later
        i_read = 1; i_address = 16'h0500;
        tick();
        chk("dr_grant_i", grant, 2'b01);
        d_read = 1; d_address = 16'h0600;
        i_read = 0;
        tick();
        chk("dr_idle", grant, 2'b00);
        tick();
        chk("dr_grant_d", grant, 2'b10);
        pmem_resp = 1; tick(); pmem_resp = 0; d_read = 0;

        // abort leaves last owner (D) untouched: I wins the next tie
        i_read = 1;
        tick();
        chk("ab_grant_i", grant, 2'b01);
        i_read = 0;
        tick();
        i_read = 1; d_read = 1;
        tick();
        chk("ab_tie", grant, 2'b01);
        i_read = 0; d_read = 0;
        tick(); tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, physical address width.
REQ-002 The block SHALL have parameter LINE_W, default 128, cache-line data width.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset.
REQ-004 Port: clk  in  1  rising-edge clock for all state.
REQ-005 Port: rst_n  in  1  synchronous active-low reset.
REQ-006 Port: i_read / i_write  in  1 each  instruction-cache line read/write request.
REQ-007 Port: i_address  in  ADDR_W  instruction-cache line address.
REQ-008 Port: i_wdata  in  LINE_W  instruction-cache write line.
REQ-009 Port: i_resp  out  1  instruction-cache transaction complete.
REQ-010 Port: i_rdata  out  LINE_W  instruction-cache read line.
REQ-011 Port: d_read / d_write / d_address / d_wdata / d_resp / d_rdata SHALL mirror REQ-006..REQ-010 for the data cache.
REQ-012 Port: pmem_read / pmem_write  out  1 each  downstream physical-memory request.
REQ-013 Port: pmem_address  out  ADDR_W  downstream line address.
REQ-014 Port: pmem_wdata  out  LINE_W  downstream write line.
REQ-015 Port: pmem_resp  in  1  downstream completion.
REQ-016 Port: pmem_rdata  in  LINE_W  downstream read line.
REQ-017 Port: grant  out  2  current owner: 00 none, 01 I, 10 D.

Function
REQ-018 The FSM SHALL have three states: IDLE, GNT_I, GNT_D; grant SHALL equal the state encoding.
REQ-019 Define req_I = i_read|i_write and req_D = d_read|d_write.
REQ-020 In IDLE, pmem_read, pmem_write, i_resp and d_resp SHALL be 0, and pmem_address/pmem_wdata SHALL be 0.
REQ-021 In IDLE with only req_I (only req_D), next state SHALL be GNT_I (GNT_D).
REQ-022 In IDLE with req_I and req_D both set, the client other than last_owner SHALL be granted (round-robin).
REQ-023 last_owner SHALL update to the granted client on the cycle the transaction completes.
REQ-024 Grant latency: a request sampled in IDLE at edge N SHALL drive pmem_* from edge N onward (one cycle).
REQ-025 In GNT_x, pmem_read/pmem_write/pmem_address/pmem_wdata SHALL combinationally follow client x.
REQ-026 If client x asserts read and write together, pmem_write SHALL be 1 and pmem_read SHALL be 0.
REQ-027 In GNT_x, x_resp SHALL equal pmem_resp; the other client's resp SHALL be 0.
REQ-028 i_rdata and d_rdata SHALL both equal pmem_rdata at all times; only resp qualifies them.
REQ-029 In GNT_x, pmem_resp=1 SHALL move the FSM to IDLE at the next edge, giving one idle cycle between transactions.
REQ-030 In GNT_x, if client x drops both read and write before pmem_resp, the FSM SHALL return to IDLE at the next edge; last_owner SHALL be unchanged.
REQ-031 The non-granted client's request SHALL be held pending without any response until it is granted.
REQ-032 Fairness: a continuously requesting client SHALL be granted after at most one transaction of the other client.
REQ-033 pmem_resp received in IDLE SHALL be ignored.

Reset
REQ-034 With rst_n=0 at an edge, the state SHALL become IDLE, last_owner SHALL become D, and grant SHALL become 00; all outputs SHALL follow REQ-020.
REQ-035 Reset asserted mid-transaction SHALL abort the grant at that edge; no resp SHALL be forwarded afterwards.
REQ-036 The first simultaneous request after reset SHALL be granted to I.

Verification
REQ-037 Single I read of 0x0010: i_read held -> grant=01 after 1 cycle, pmem_read=1, pmem_address=0x0010, i_resp pulses with pmem_resp, d_resp=0.
REQ-038 Simultaneous I read 0x0020 and D write 0x1230 (wdata 0x600D repeated) after reset -> I served first; IDLE for 1 cycle; then D served with pmem_write=1 and pmem_wdata matching.
REQ-039 Both clients request continuously for 4 transactions -> grant order I, D, I, D.
REQ-040 D write-back followed by D read (dirty miss) while I waits -> order D-write, I, D-read.
REQ-041 rst_n=0 during GNT_D before pmem_resp -> next cycle grant=00, pmem_read=pmem_write=0, d_resp stays 0.
REQ-042 A client drops its request while granted -> IDLE next cycle, and a pending other client is granted one cycle later.
